gal_tri_bus_arbiter: RTL

Round-robin arbiter that shares one tri-stated GAL bus (pins driven by `GAL_TRI` / `GAL_TRI_N` macrocells) between up to eight requesters. It generates the one-hot grant vector and the per-requester output-enable lines that feed the `E` inputs of the tri-state OLMCs. It enforces a bounded tenure per owner and a mandatory bus-idle turnaround between owners, so that no two OLMCs ever drive the shared pins at once. It sits between requester logic and the tri-state output macrocells and is fully synchronous to the OLMC clock.

---
 rtl/gal_tri_bus_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/gal_tri_bus_arbiter.sv
// Round-robin owner arbiter for a shared tri-stated GAL bus: one-hot grant / OLMC
// output enables, bounded tenure under contention and a forced all-idle turnaround.
module gal_tri_bus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int HOLD_MAX   = 8,
    parameter int TURNAROUND = 1,
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int HW = $clog2(HOLD_MAX + 1)
) (
    input  logic             C,
    input  logic             R,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic [N_REQ-1:0] OE,
    output logic [IW-1:0]    OWNER,
    output logic             BUSY
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

    state_t           state_q;
    logic [IW-1:0]    ptr_q;
    logic [HW-1:0]    hold_q;
    logic [1:0]       turn_q;
    logic [N_REQ-1:0] gnt_q;
    logic [IW-1:0]    owner_q;
    logic             busy_q;

    logic             sel_vld;
    logic [IW-1:0]    sel_idx;
    logic             own_req;
    logic             other_req;
    logic             release_now;
    logic [IW-1:0]    ptr_next;

    // Scan from the highest offset down so the nearest request above ptr wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (REQ[(int'(ptr_q) + k) % N_REQ]) begin
                sel_vld = 1'b1;
                sel_idx = IW'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    assign own_req     = |(REQ & gnt_q);
    assign other_req   = |(REQ & ~gnt_q);
    assign release_now = !own_req || ((hold_q >= HW'(HOLD_MAX - 1)) && other_req);
    assign ptr_next    = IW'((int'(owner_q) + 1) % N_REQ);

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
            gnt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sel_vld) begin
                        gnt_q   <= N_REQ'(1) << sel_idx;
                        owner_q <= sel_idx;
                        hold_q  <= '0;
                        state_q <= S_GRANT;
                        busy_q  <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (release_now) begin
                        gnt_q   <= '0;
                        ptr_q   <= ptr_next;
                        turn_q  <= '0;
                        state_q <= S_TURN;
                    end else if (hold_q != HW'(HOLD_MAX)) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                S_TURN: begin
                    // Requests are only looked at once the idle gap is complete.
                    if (turn_q == 2'(TURNAROUND - 1)) begin
                        if (sel_vld) begin
                            gnt_q   <= N_REQ'(1) << sel_idx;
                            owner_q <= sel_idx;
                            hold_q  <= '0;
                            state_q <= S_GRANT;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        turn_q <= turn_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign GNT   = gnt_q;
    assign OE    = gnt_q;
    assign OWNER = owner_q;
    assign BUSY  = busy_q;

endmodule
